// File: rtl/gmii_frame_tx_pkg.sv
// Shared GMII transmit constants, FSM state encoding and an FCS residue helper
// for the matching receive-side checker.
package gmii_frame_tx_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_DRAIN,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } tx_state_e;

   // The reflected CRC register holds the residue in bit-reversed form.
   function automatic logic residue_ok(input logic [31:0] crc_reg);
      logic [31:0] rev;
      for (int i = 0; i < 32; i++) rev[i] = crc_reg[31-i];
      return rev == CRC_RESIDUE;
   endfunction

endpackage

// File: rtl/gmii_frame_tx_crc32_byte.sv
// Combinational Ethernet CRC-32 (reflected) update for one byte; shared with the
// receive-side FCS checker.
module crc32_byte
   import gmii_frame_tx_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in ^ {24'h0, data_in};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/gmii_frame_tx.sv
// GMII frame transmitter: preamble, SFD, payload, zero pad, CRC-32 FCS and IFG,
// with an SFD pulse for PTP egress timestamping.
module gmii_frame_tx
   import gmii_frame_tx_pkg::*;
#(
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_LEN      = 12,
   parameter int MIN_PAYLOAD  = 60,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 gmii_tx_clk,
   input  logic                 reset,
   input  logic                 s_tvalid,
   input  logic [7:0]           s_tdata,
   input  logic                 s_tlast,
   output logic                 s_tready,
   output logic [7:0]           gmii_txd,
   output logic                 gmii_txen,
   output logic                 gmii_txer,
   output logic                 sof_pulse,
   output logic                 eof_pulse,
   output logic                 tx_busy,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic [CNT_WIDTH-1:0] underrun_cnt
);

   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);
   localparam logic [15:0] MIN_PL   = 16'(MIN_PAYLOAD);

   tx_state_e             state_q, state_d;
   logic [15:0]           phase_q, phase_d;
   logic [15:0]           byte_cnt_q, byte_cnt_d;
   logic [31:0]           crc_q, crc_d;
   logic [7:0]            txd_q, txd_d;
   logic                  txen_q, txen_d;
   logic                  txer_q, txer_d;
   logic                  sof_q, sof_d;
   logic                  eof_q, eof_d;
   logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_WIDTH-1:0]  underrun_cnt_q, underrun_cnt_d;

   logic [7:0]            crc_data;
   logic [31:0]           crc_next;
   logic [31:0]           fcs_word;

   // Pad bytes are zeros but still covered by the FCS.
   assign crc_data = (state_q == ST_PAD) ? 8'h00 : s_tdata;
   assign fcs_word = ~crc_q;

   crc32_byte u_crc (
      .crc_in  (crc_q),
      .data_in (crc_data),
      .crc_out (crc_next)
   );

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      byte_cnt_d     = byte_cnt_q;
      crc_d          = crc_q;
      txd_d          = 8'h00;
      txen_d         = 1'b0;
      txer_d         = 1'b0;
      sof_d          = 1'b0;
      eof_d          = 1'b0;
      frame_cnt_d    = frame_cnt_q;
      underrun_cnt_d = underrun_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            phase_d = 16'd0;
            if (s_tvalid) state_d = ST_PREAMBLE;
         end
         ST_PREAMBLE: begin
            txd_d  = PREAMBLE_BYTE;
            txen_d = 1'b1;
            if (phase_q == PRE_LAST) begin
               phase_d = 16'd0;
               state_d = ST_SFD;
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
         ST_SFD: begin
            txd_d      = SFD_BYTE;
            txen_d     = 1'b1;
            sof_d      = 1'b1;
            crc_d      = CRC_INIT;
            byte_cnt_d = 16'd0;
            state_d    = ST_DATA;
         end
         ST_DATA: begin
            txen_d = 1'b1;
            if (s_tvalid) begin
               txd_d      = s_tdata;
               crc_d      = crc_next;
               byte_cnt_d = (byte_cnt_q < MIN_PL) ? byte_cnt_q + 16'd1 : byte_cnt_q;
               if (s_tlast) begin
                  phase_d = 16'd0;
                  state_d = ((byte_cnt_q + 16'd1) < MIN_PL) ? ST_PAD : ST_FCS;
               end
            end else begin
               // Underrun: flag one errored byte, then stop driving the frame.
               txer_d         = 1'b1;
               underrun_cnt_d = underrun_cnt_q + 1'b1;
               state_d        = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (s_tvalid && s_tlast) begin
               phase_d = 16'd0;
               state_d = ST_IFG;
            end
         end
         ST_PAD: begin
            txen_d     = 1'b1;
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_q + 16'd1;
            if ((byte_cnt_q + 16'd1) >= MIN_PL) begin
               phase_d = 16'd0;
               state_d = ST_FCS;
            end
         end
         ST_FCS: begin
            txd_d  = fcs_word[{phase_q[1:0], 3'b000} +: 8];
            txen_d = 1'b1;
            if (phase_q[1:0] == 2'd3) begin
               eof_d       = 1'b1;
               frame_cnt_d = frame_cnt_q + 1'b1;
               phase_d     = 16'd0;
               state_d     = ST_IFG;
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
         ST_IFG: begin
            if (phase_q == IFG_LAST) begin
               // A waiting frame starts right away so the gap stays exactly IFG_LEN.
               phase_d = 16'd0;
               state_d = s_tvalid ? ST_PREAMBLE : ST_IDLE;
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge gmii_tx_clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         phase_q        <= 16'd0;
         byte_cnt_q     <= 16'd0;
         crc_q          <= CRC_INIT;
         txd_q          <= 8'h00;
         txen_q         <= 1'b0;
         txer_q         <= 1'b0;
         sof_q          <= 1'b0;
         eof_q          <= 1'b0;
         frame_cnt_q    <= '0;
         underrun_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         byte_cnt_q     <= byte_cnt_d;
         crc_q          <= crc_d;
         txd_q          <= txd_d;
         txen_q         <= txen_d;
         txer_q         <= txer_d;
         sof_q          <= sof_d;
         eof_q          <= eof_d;
         frame_cnt_q    <= frame_cnt_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   // s_tready: a byte moves on any clock edge where s_tvalid && s_tready.
   assign s_tready     = !reset && ((state_q == ST_DATA) || (state_q == ST_DRAIN));
   assign tx_busy      = (state_q != ST_IDLE);
   assign gmii_txd     = txd_q;
   assign gmii_txen    = txen_q;
   assign gmii_txer    = txer_q;
   assign sof_pulse    = sof_q;
   assign eof_pulse    = eof_q;
   assign frame_cnt    = frame_cnt_q;
   assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Bench for gmii_frame_tx: a no-pad/2-bit-counter instance and a default instance.
module tb_gmii_frame_tx;

   logic clk = 1'b0;
   always #4 clk = ~clk;

   logic [1:0] rst;
   logic [1:0] s_tvalid;
   logic [1:0] s_tlast;
   logic [7:0] s_tdata [2];

   logic       rdy0, txen0, txer0, sof0, eof0, busy0;
   logic [7:0] txd0;
   logic [1:0] fc0, uc0;
   logic       rdy1, txen1, txer1, sof1, eof1, busy1;
   logic [7:0] txd1;
   logic [15:0] fc1, uc1;

   gmii_frame_tx #(.PREAMBLE_LEN(7), .IFG_LEN(12), .MIN_PAYLOAD(0), .CNT_WIDTH(2)) dut0 (
      .gmii_tx_clk (clk),
      .reset       (rst[0]),
      .s_tvalid    (s_tvalid[0]),
      .s_tdata     (s_tdata[0]),
      .s_tlast     (s_tlast[0]),
      .s_tready    (rdy0),
      .gmii_txd    (txd0),
      .gmii_txen   (txen0),
      .gmii_txer   (txer0),
      .sof_pulse   (sof0),
      .eof_pulse   (eof0),
      .tx_busy     (busy0),
      .frame_cnt   (fc0),
      .underrun_cnt(uc0)
   );

   gmii_frame_tx dut1 (
      .gmii_tx_clk (clk),
      .reset       (rst[1]),
      .s_tvalid    (s_tvalid[1]),
      .s_tdata     (s_tdata[1]),
      .s_tlast     (s_tlast[1]),
      .s_tready    (rdy1),
      .gmii_txd    (txd1),
      .gmii_txen   (txen1),
      .gmii_txer   (txer1),
      .sof_pulse   (sof1),
      .eof_pulse   (eof1),
      .tx_busy     (busy1),
      .frame_cnt   (fc1),
      .underrun_cnt(uc1)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] pay_q[$];

   // Frame monitor on the default instance.
   logic [7:0] mon_q[$];
   int         run_len = 0, gap_len = 0, last_gap = 0;
   int         txer_cycles = 0, sof_cnt = 0, eof_cnt = 0;
   logic [7:0] txer_txd = 8'hFF;
   logic       prev_en = 1'b0;

   always @(negedge clk) begin
      if (txen1 && !prev_en) begin
         mon_q.delete();
         run_len  = 0;
         last_gap = gap_len;
      end
      if (txen1) begin
         mon_q.push_back(txd1);
         run_len++;
         gap_len = 0;
      end else begin
         gap_len++;
      end
      if (txer1) begin
         txer_cycles++;
         txer_txd = txd1;
      end
      if (sof1) sof_cnt++;
      if (eof1) eof_cnt++;
      prev_en = txen1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input int d);
      return (d == 0) ? rdy0 : rdy1;
   endfunction

   function automatic logic bsy(input int d);
      return (d == 0) ? busy0 : busy1;
   endfunction

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic put_byte(input int d, input logic [7:0] b, input logic l);
      int g;
      g = 0;
      s_tvalid[d] = 1'b1;
      s_tdata[d]  = b;
      s_tlast[d]  = l;
      while (!rdy(d) && g < 2000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 2000) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: dut%0d s_tready never rose, expected 1", d);
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input int d, input logic drop);
      for (int i = 0; i < pay_q.size(); i++) put_byte(d, pay_q[i], i == pay_q.size() - 1);
      if (drop) begin
         s_tvalid[d] = 1'b0;
         s_tlast[d]  = 1'b0;
      end
   endtask

   task automatic wait_idle(input int d);
      int g;
      g = 0;
      @(negedge clk);
      while (bsy(d) && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 5000) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: dut%0d tx_busy stuck at 1, expected 0", d);
      end
   endtask

   task automatic build_exp(input int min_pl);
      logic [31:0] c;
      int n;
      exp_q.delete();
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      c = 32'hFFFFFFFF;
      n = 0;
      foreach (pay_q[i]) begin
         exp_q.push_back(pay_q[i]);
         c = crc_upd(c, pay_q[i]);
         n++;
      end
      while (n < min_pl) begin
         exp_q.push_back(8'h00);
         c = crc_upd(c, 8'h00);
         n++;
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
   endtask

   task automatic check_frame(input string name, input int exp_len);
      int mism;
      logic [31:0] c, rev;
      mism = 0;
      check({name, "_txen_len"}, run_len, exp_len);
      check({name, "_size"}, mon_q.size(), exp_q.size());
      for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++)
         if (mon_q[i] !== exp_q[i]) mism++;
      check({name, "_byte_mismatches"}, mism, 0);
      c = 32'hFFFFFFFF;
      for (int i = 8; i < mon_q.size(); i++) c = crc_upd(c, mon_q[i]);
      for (int i = 0; i < 32; i++) rev[i] = c[31-i];
      check({name, "_residue"}, rev, 32'hC704DD7B);
   endtask

   typedef struct {
      logic        vld;
      logic [7:0]  data;
      logic        last;
      logic [13:0] exp;
   } vec_t;

   vec_t       tbl[24];
   logic [7:0] fcs_ref[4];

   function automatic logic [13:0] mk(input logic en, input logic er, input logic [7:0] d,
                                      input logic so, input logic eo, input logic rd, input logic bz);
      return {en, er, d, so, eo, rd, bz};
   endfunction

   initial begin
      int s_txer, s_eof, s_sof;
      logic [7:0] d;

      // "123456789" cycle table for the no-pad instance; row i = cycle i after reset release.
      fcs_ref[0] = 8'h26; fcs_ref[1] = 8'h39; fcs_ref[2] = 8'hF4; fcs_ref[3] = 8'hCB;
      for (int i = 0; i < 24; i++) begin
         tbl[i].vld  = (i <= 17);
         tbl[i].data = (i <= 9) ? 8'h31 : (i <= 17) ? 8'(32'h31 + i - 9) : 8'h00;
         tbl[i].last = (i == 17);
         if (i >= 2 && i <= 8)       d = 8'h55;
         else if (i == 9)            d = 8'hD5;
         else if (i >= 10 && i <= 18) d = 8'(32'h31 + i - 10);
         else if (i >= 19 && i <= 22) d = fcs_ref[i-19];
         else                        d = 8'h00;
         tbl[i].exp = mk(i >= 2 && i <= 22, 1'b0, d, i == 9, i == 22,
                         i >= 9 && i <= 17, i >= 1);
      end

      rst = 2'b11;
      s_tvalid = 2'b00;
      s_tlast = 2'b00;
      s_tdata[0] = 8'h00;
      s_tdata[1] = 8'h00;
      repeat (3) @(negedge clk);
      rst = 2'b00;

      check("reset_fc0", fc0, 0);
      check("reset_uc0", uc0, 0);
      check("reset_fc1", fc1, 0);
      check("reset_out1", {txen1, txer1, txd1, sof1, eof1, rdy1, busy1}, 0);

      // Test 1: table-driven frame without padding.
      for (int i = 0; i < 24; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("vec%0d", i), {txen0, txer0, txd0, sof0, eof0, rdy0, busy0}, tbl[i].exp);
         s_tvalid[0] = tbl[i].vld;
         s_tdata[0]  = tbl[i].data;
         s_tlast[0]  = tbl[i].last;
      end
      check("t1_frame_cnt", fc0, 1);
      wait_idle(0);

      // Test 6: single-byte frames, counter wraps modulo 4.
      for (int k = 2; k <= 5; k++) begin
         pay_q = '{8'(8'hA0 + k)};
         send_frame(0, 1'b1);
         wait_idle(0);
         check($sformatf("t6_frame_cnt_%0d", k), fc0, k % 4);
      end
      check("t6_underrun_cnt", uc0, 0);

      // Test 2: 4-byte payload padded to 60.
      s_sof = sof_cnt;
      s_eof = eof_cnt;
      pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      build_exp(60);
      send_frame(1, 1'b1);
      wait_idle(1);
      check_frame("t2", 72);
      check("t2_frame_cnt", fc1, 1);
      check("t2_sof_count", sof_cnt - s_sof, 1);
      check("t2_eof_count", eof_cnt - s_eof, 1);

      // Test 3: underrun after 10 bytes, remainder drained.
      s_txer = txer_cycles;
      s_eof  = eof_cnt;
      for (int i = 0; i < 10; i++) put_byte(1, 8'(8'h10 + i), 1'b0);
      s_tvalid[1] = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) put_byte(1, 8'(8'h20 + i), i == 4);
      s_tvalid[1] = 1'b0;
      s_tlast[1]  = 1'b0;
      wait_idle(1);
      check("t3_txer_cycles", txer_cycles - s_txer, 1);
      check("t3_txer_txd", txer_txd, 8'h00);
      check("t3_txen_len", run_len, 19);
      check("t3_underrun_cnt", uc1, 1);
      check("t3_frame_cnt", fc1, 1);
      check("t3_no_eof", eof_cnt - s_eof, 0);

      // Test 4: back-to-back frames with s_tvalid held.
      pay_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      send_frame(1, 1'b0);
      pay_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
      build_exp(60);
      send_frame(1, 1'b1);
      wait_idle(1);
      check("t4_gap", last_gap, 12);
      check_frame("t4", 72);
      check("t4_frame_cnt", fc1, 3);

      // Test 5: reset during DATA, then a clean 60-byte frame.
      for (int i = 0; i < 3; i++) put_byte(1, 8'(8'h70 + i), 1'b0);
      rst[1] = 1'b1;
      s_tvalid[1] = 1'b0;
      @(negedge clk);
      check("t5_txen_after_reset", txen1, 0);
      check("t5_busy_after_reset", busy1, 0);
      check("t5_fc_after_reset", fc1, 0);
      check("t5_uc_after_reset", uc1, 0);
      rst[1] = 1'b0;
      pay_q.delete();
      for (int i = 0; i < 60; i++) pay_q.push_back(8'(8'h40 + i));
      build_exp(60);
      send_frame(1, 1'b1);
      wait_idle(1);
      check_frame("t5", 72);
      check("t5_frame_cnt", fc1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
